// File: rtl/key_pulse_replayer.sv
// Replays one-clock press pulses as fixed-width held pulses separated by a low gap, queueing late presses.
// Optional build macro RETRIGGER_EN: a press during HOLD restarts the hold instead of queueing.
module key_pulse_replayer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_DEPTH = 3,
    parameter int CW          = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in,
    input  logic       ovf_clr,
    output logic       out,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    DEPTH     = 4'(QUEUE_DEPTH);

    state_t        state;
    logic [CW-1:0] counter;

    logic cnt_done;
    logic retrigger;
    logic consume;
    logic enqueue;
    logic drop;

    // Queue bookkeeping decided combinationally so the state register sees one consistent view.
    always_comb begin
        cnt_done = (counter == '0);
`ifdef RETRIGGER_EN
        retrigger = in && (state == HOLD);
`else
        retrigger = 1'b0;
`endif
        consume = (state == GAP) && cnt_done && ((pending != 4'd0) || in);
        enqueue = in && (state != IDLE) && !retrigger && !consume;
        drop    = enqueue && (pending == DEPTH);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            counter  <= '0;
            out      <= 1'b0;
            busy     <= 1'b0;
            pending  <= 4'd0;
            overflow <= 1'b0;
        end else begin
            // NOTE: a drop and ovf_clr on the same edge must leave the flag set, so set has priority.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            // A consume with a simultaneous press cancels out: the new press takes the freed slot.
            if (consume && !in) begin
                pending <= pending - 4'd1;
            end else if (enqueue && !drop) begin
                pending <= pending + 4'd1;
            end

            unique case (state)
                IDLE: begin
                    if (in) begin
                        state   <= HOLD;
                        counter <= HOLD_LOAD;
                        out     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (retrigger) begin
                        counter <= HOLD_LOAD;
                    end else if (cnt_done) begin
                        state   <= GAP;
                        counter <= GAP_LOAD;
                        out     <= 1'b0;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
                GAP: begin
                    if (consume) begin
                        state   <= HOLD;
                        counter <= HOLD_LOAD;
                        out     <= 1'b1;
                    end else if (cnt_done) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    out     <= 1'b0;
                    busy    <= 1'b0;
                    pending <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_pulse_replayer.sv
// Table-driven bench for key_pulse_replayer at default parameters (HOLD=4, GAP=2, DEPTH=3).
module tb_key_pulse_replayer;

    logic       Clock;
    logic       Reset;
    logic       in;
    logic       ovf_clr;
    logic       out;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    key_pulse_replayer #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .QUEUE_DEPTH(3),
        .CW         (8)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .in      (in),
        .ovf_clr (ovf_clr),
        .out     (out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        logic       rst;
        logic       in_v;
        logic       clr;
        logic       exp_out;
        logic       exp_busy;
        logic [3:0] exp_pend;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    // Append n identical rows: inputs for one edge and the outputs expected just after it.
    function automatic void rep(input string name, input int n,
                                input bit rst, input bit in_v, input bit clr,
                                input bit o, input bit b, input int p, input bit ov);
        vec_t v;
        v.name     = name;
        v.rst      = rst;
        v.in_v     = in_v;
        v.clr      = clr;
        v.exp_out  = o;
        v.exp_busy = b;
        v.exp_pend = 4'(p);
        v.exp_ovf  = ov;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check_row(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got out=%b busy=%b pending=%0d overflow=%b, expected out=%b busy=%b pending=%0d overflow=%b",
                     name, act[6], act[5], act[4:1], act[0], exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        Reset   = 1'b1;
        in      = 1'b0;
        ovf_clr = 1'b0;

        // t1: single press
        rep("t1", 1, 1,0,0, 0,0,0,0);
        rep("t1", 1, 0,1,0, 1,1,0,0);
        rep("t1", 3, 0,0,0, 1,1,0,0);
        rep("t1", 2, 0,0,0, 0,1,0,0);
        rep("t1", 2, 0,0,0, 0,0,0,0);

`ifndef RETRIGGER_EN
        // t2: three presses back to back, two queued
        rep("t2", 1, 1,0,0, 0,0,0,0);
        rep("t2", 1, 0,1,0, 1,1,0,0);
        rep("t2", 1, 0,1,0, 1,1,1,0);
        rep("t2", 1, 0,1,0, 1,1,2,0);
        rep("t2", 1, 0,0,0, 1,1,2,0);
        rep("t2", 2, 0,0,0, 0,1,2,0);
        rep("t2", 4, 0,0,0, 1,1,1,0);
        rep("t2", 2, 0,0,0, 0,1,1,0);
        rep("t2", 4, 0,0,0, 1,1,0,0);
        rep("t2", 2, 0,0,0, 0,1,0,0);
        rep("t2", 1, 0,0,0, 0,0,0,0);

        // t3a: five presses, one dropped, four replays, then clear
        rep("t3a", 1, 1,0,0, 0,0,0,0);
        rep("t3a", 1, 0,1,0, 1,1,0,0);
        rep("t3a", 1, 0,1,0, 1,1,1,0);
        rep("t3a", 1, 0,1,0, 1,1,2,0);
        rep("t3a", 1, 0,1,0, 1,1,3,0);
        rep("t3a", 1, 0,1,0, 0,1,3,1);
        rep("t3a", 1, 0,0,0, 0,1,3,1);
        rep("t3a", 4, 0,0,0, 1,1,2,1);
        rep("t3a", 2, 0,0,0, 0,1,2,1);
        rep("t3a", 4, 0,0,0, 1,1,1,1);
        rep("t3a", 2, 0,0,0, 0,1,1,1);
        rep("t3a", 4, 0,0,0, 1,1,0,1);
        rep("t3a", 2, 0,0,0, 0,1,0,1);
        rep("t3a", 1, 0,0,0, 0,0,0,1);
        rep("t3a", 1, 0,0,1, 0,0,0,0);
        rep("t3a", 1, 0,0,0, 0,0,0,0);

        // t3b: drop with ovf_clr on the same edge; press on the consume edge never overflows
        rep("t3b", 1, 1,0,0, 0,0,0,0);
        rep("t3b", 1, 0,1,0, 1,1,0,0);
        rep("t3b", 1, 0,1,0, 1,1,1,0);
        rep("t3b", 1, 0,1,0, 1,1,2,0);
        rep("t3b", 1, 0,1,0, 1,1,3,0);
        rep("t3b", 1, 0,1,1, 0,1,3,1);
        rep("t3b", 1, 0,0,1, 0,1,3,0);
        rep("t3b", 1, 0,1,0, 1,1,3,0);
        rep("t3b", 1, 0,1,1, 1,1,3,1);
`endif

        // t4: press on the final GAP edge starts a new HOLD with no IDLE cycle
        rep("t4", 1, 1,0,0, 0,0,0,0);
        rep("t4", 1, 0,1,0, 1,1,0,0);
        rep("t4", 3, 0,0,0, 1,1,0,0);
        rep("t4", 2, 0,0,0, 0,1,0,0);
        rep("t4", 1, 0,1,0, 1,1,0,0);
        rep("t4", 3, 0,0,0, 1,1,0,0);
        rep("t4", 2, 0,0,0, 0,1,0,0);
        rep("t4", 1, 0,0,0, 0,0,0,0);

`ifndef RETRIGGER_EN
        // t5: reset mid-HOLD with two queued and overflow set; reset beats a concurrent press
        rep("t5", 1, 1,0,0, 0,0,0,0);
        rep("t5", 1, 0,1,0, 1,1,0,0);
        rep("t5", 1, 0,1,0, 1,1,1,0);
        rep("t5", 1, 0,1,0, 1,1,2,0);
        rep("t5", 1, 0,1,0, 1,1,3,0);
        rep("t5", 1, 0,1,0, 0,1,3,1);
        rep("t5", 1, 0,0,0, 0,1,3,1);
        rep("t5", 1, 0,0,0, 1,1,2,1);
        rep("t5", 1, 1,1,0, 0,0,0,0);
        rep("t5", 1, 0,0,0, 0,0,0,0);
        rep("t5", 1, 0,1,0, 1,1,0,0);
        rep("t5", 3, 0,0,0, 1,1,0,0);
        rep("t5", 2, 0,0,0, 0,1,0,0);
        rep("t5", 1, 0,0,0, 0,0,0,0);

        // t6: presses at edges 0 and 2 give two replays
        rep("t6", 1, 1,0,0, 0,0,0,0);
        rep("t6", 1, 0,1,0, 1,1,0,0);
        rep("t6", 1, 0,0,0, 1,1,0,0);
        rep("t6", 1, 0,1,0, 1,1,1,0);
        rep("t6", 1, 0,0,0, 1,1,1,0);
        rep("t6", 2, 0,0,0, 0,1,1,0);
        rep("t6", 4, 0,0,0, 1,1,0,0);
        rep("t6", 2, 0,0,0, 0,1,0,0);
        rep("t6", 1, 0,0,0, 0,0,0,0);
`else
        // t6: the press at edge 2 extends the hold instead of queueing
        rep("t6r", 1, 1,0,0, 0,0,0,0);
        rep("t6r", 1, 0,1,0, 1,1,0,0);
        rep("t6r", 1, 0,0,0, 1,1,0,0);
        rep("t6r", 1, 0,1,0, 1,1,0,0);
        rep("t6r", 3, 0,0,0, 1,1,0,0);
        rep("t6r", 2, 0,0,0, 0,1,0,0);
        rep("t6r", 1, 0,0,0, 0,0,0,0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            Reset   = vecs[i].rst;
            in      = vecs[i].in_v;
            ovf_clr = vecs[i].clr;
            @(posedge Clock);
            #1;
            check_row($sformatf("%s[%0d]", vecs[i].name, i),
                      {out, busy, pending, overflow},
                      {vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_pend, vecs[i].exp_ovf});
        end

        // Held press for three cycles: count replays until the block goes idle again.
        begin
            int  rises;
            int  max_pend;
            bit  prev_out;
            bit  done;
            rises    = 0;
            max_pend = 0;
            prev_out = 1'b0;
            done     = 1'b0;
            @(negedge Clock);
            Reset   = 1'b1;
            in      = 1'b0;
            ovf_clr = 1'b0;
            for (int cyc = -1; cyc < 80 && !done; cyc++) begin
                @(negedge Clock);
                Reset = (cyc < 0);
                in    = (cyc >= 0) && (cyc < 3);
                @(posedge Clock);
                #1;
                if (cyc >= 0) begin
                    if (out && !prev_out) rises++;
                    prev_out = out;
                    if (int'(pending) > max_pend) max_pend = int'(pending);
                    if (cyc >= 3 && !busy) done = 1'b1;
                end
            end
            check("held_done", int'(done), 1);
`ifdef RETRIGGER_EN
            check("held_replays", rises, 1);
            check("held_max_pending", max_pend, 0);
`else
            check("held_replays", rises, 3);
            check("held_max_pending", max_pend, 2);
`endif
            check("held_overflow", int'(overflow), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
